// File: rtl/fdiv16.sv
// fdiv16: iterative IEEE-754 binary16 divider (op1 / op2).
// Restoring division over 12 quotient bits, truncating rounding, and
// subnormal inputs flushed to zero. Special operand pairs finish in one cycle.
module fdiv16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] op1,
  input  logic [15:0] op2,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic        flag_dz,
  output logic        flag_nv,
  output logic        flag_of,
  output logic        flag_uf
);

  typedef enum logic [1:0] {IDLE = 2'd0, DIV = 2'd1, NORM = 2'd2} state_t;

  localparam logic [15:0] QNAN = 16'h7E00;

  function automatic logic is_nan(input logic [15:0] x);
    return (x[14:10] == 5'h1F) && (x[9:0] != 10'h000);
  endfunction

  function automatic logic is_inf(input logic [15:0] x);
    return (x[14:10] == 5'h1F) && (x[9:0] == 10'h000);
  endfunction

  // Zero exponent covers true zeros and the subnormals that get flushed.
  function automatic logic is_zero(input logic [15:0] x);
    return (x[14:10] == 5'h00);
  endfunction

  state_t             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [11:0]        rem_q, rem_d;
  logic [11:0]        quo_q, quo_d;
  logic [10:0]        mb_q, mb_d;
  logic signed [6:0]  exp_q, exp_d;
  logic               sign_q, sign_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [15:0]        res_q, res_d;
  logic [3:0]         flg_q, flg_d;   // {dz, nv, of, uf}

  logic               nan1_s, nan2_s, inf1_s, inf2_s, zero1_s, zero2_s;
  logic               special_s, sgn_s;
  logic [15:0]        spec_res_s;
  logic [3:0]         spec_flg_s;
  logic               ge_s;
  logic [11:0]        diff_s;
  logic signed [6:0]  nexp_s;
  logic [9:0]         nmant_s;

  assign nan1_s  = is_nan(op1);
  assign nan2_s  = is_nan(op2);
  assign inf1_s  = is_inf(op1);
  assign inf2_s  = is_inf(op2);
  assign zero1_s = is_zero(op1);
  assign zero2_s = is_zero(op2);
  assign sgn_s   = op1[15] ^ op2[15];
  assign special_s = nan1_s | nan2_s | inf1_s | inf2_s | zero1_s | zero2_s;

  // Resolve special operand pairs straight from the input operands.
  always_comb begin
    spec_res_s = {sgn_s, 15'h0000};
    spec_flg_s = 4'b0000;
    if (nan1_s || nan2_s || (zero1_s && zero2_s) || (inf1_s && inf2_s)) begin
      spec_res_s = QNAN;
      spec_flg_s = 4'b0100;
    end else if (inf1_s) begin
      spec_res_s = {sgn_s, 5'h1F, 10'h000};
    end else if (zero2_s) begin
      spec_res_s = {sgn_s, 5'h1F, 10'h000};
      spec_flg_s = 4'b1000;
    end else begin
      spec_res_s = {sgn_s, 15'h0000};
    end
  end

  // One restoring step: trial-subtract the divisor, then shift left.
  always_comb begin
    ge_s   = (rem_q >= {1'b0, mb_q});
    diff_s = ge_s ? (rem_q - {1'b0, mb_q}) : rem_q;
  end

  // Normalise the quotient; q[11]=0 means the leading one sits at q[10].
  always_comb begin
    nexp_s  = exp_q;
    nmant_s = quo_q[10:1];
    if (quo_q[11]) begin
      nexp_s  = exp_q;
      nmant_s = quo_q[10:1];
    end else begin
      nexp_s  = exp_q - 7'sd1;
      nmant_s = quo_q[9:0];
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start && !special_s) state_d = DIV;
        else                     state_d = IDLE;
      end
      DIV: begin
        if (cnt_q == 4'd11) state_d = NORM;
        else                state_d = DIV;
      end
      NORM:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output next values per state.
  always_comb begin
    cnt_d  = cnt_q;
    rem_d  = rem_q;
    quo_d  = quo_q;
    mb_d   = mb_q;
    exp_d  = exp_q;
    sign_d = sign_q;
    busy_d = busy_q;
    done_d = 1'b0;
    res_d  = res_q;
    flg_d  = flg_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (special_s) begin
            res_d  = spec_res_s;
            flg_d  = spec_flg_s;
            done_d = 1'b1;
          end else begin
            rem_d  = {1'b0, 1'b1, op1[9:0]};
            mb_d   = {1'b1, op2[9:0]};
            exp_d  = $signed({2'b00, op1[14:10]}) - $signed({2'b00, op2[14:10]}) + 7'sd15;
            sign_d = sgn_s;
            quo_d  = 12'h000;
            cnt_d  = 4'd0;
            busy_d = 1'b1;
          end
        end else begin
          done_d = 1'b0;
        end
      end
      DIV: begin
        rem_d = diff_s << 1;
        quo_d = {quo_q[10:0], ge_s};
        if (cnt_q == 4'd11) cnt_d = 4'd0;
        else                cnt_d = cnt_q + 4'd1;
      end
      NORM: begin
        busy_d = 1'b0;
        done_d = 1'b1;
        if (nexp_s >= 7'sd31) begin
          res_d = {sign_q, 5'h1F, 10'h000};
          flg_d = 4'b0010;
        end else if (nexp_s <= 7'sd0) begin
          res_d = {sign_q, 15'h0000};
          flg_d = 4'b0001;
        end else begin
          res_d = {sign_q, nexp_s[4:0], nmant_s};
          flg_d = 4'b0000;
        end
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= 4'd0;
      rem_q  <= 12'h000;
      quo_q  <= 12'h000;
      mb_q   <= 11'h000;
      exp_q  <= 7'sd0;
      sign_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      res_q  <= 16'h0000;
      flg_q  <= 4'b0000;
    end else begin
      cnt_q  <= cnt_d;
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      mb_q   <= mb_d;
      exp_q  <= exp_d;
      sign_q <= sign_d;
      busy_q <= busy_d;
      done_q <= done_d;
      res_q  <= res_d;
      flg_q  <= flg_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign result  = res_q;
  assign flag_dz = flg_q[3];
  assign flag_nv = flg_q[2];
  assign flag_of = flg_q[1];
  assign flag_uf = flg_q[0];

endmodule

// File: tb/tb_fdiv16.sv
// tb_fdiv16: scoreboard bench for the FP16 divider.
module tb_fdiv16;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] op1, op2;
  logic        busy, done;
  logic [15:0] result;
  logic        flag_dz, flag_nv, flag_of, flag_uf;

  typedef struct {
    logic [15:0] res;
    logic [3:0]  flg;   // {dz, nv, of, uf}
    int          lat;
    int          t0;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  fdiv16 dut (
    .clk(clk), .rst(rst), .start(start), .op1(op1), .op2(op2),
    .busy(busy), .done(done), .result(result),
    .flag_dz(flag_dz), .flag_nv(flag_nv), .flag_of(flag_of), .flag_uf(flag_uf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, wanted %h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every done pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        chk("spurious_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", {16'h0, result}, {16'h0, e.res});
        chk("flags", {28'h0, flag_dz, flag_nv, flag_of, flag_uf}, {28'h0, e.flg});
        chk("latency", cyc - e.t0, e.lat);
        chk("busy_at_done", {31'h0, busy}, 32'd0);
      end
    end
  end

  // Drive one request; returns just after the accepting edge.
  task automatic issue(input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] r, input logic [3:0] f, input int lat);
    exp_t e;
    op1   = a;
    op2   = b;
    start = 1'b1;
    e.res = r; e.flg = f; e.lat = lat; e.t0 = cyc;
    sb.push_back(e);
    @(posedge clk); #2;
    start = 1'b0;
    chk("busy_after_accept", {31'h0, busy}, (lat == 14) ? 32'd1 : 32'd0);
  endtask

  // Wait (bounded) until done is high, sampled just after an edge.
  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (done) seen = 1'b1;
      else begin
        @(posedge clk); #2;
      end
    end
    if (!seen) chk("timeout", 32'd0, 32'd1);
  endtask

  task automatic run(input logic [15:0] a, input logic [15:0] b,
                     input logic [15:0] r, input logic [3:0] f, input int lat);
    issue(a, b, r, f, lat);
    wait_done();
    @(posedge clk); #2;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op1 = 16'h0; op2 = 16'h0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_busy",   {31'h0, busy}, 32'd0);
    chk("rst_done",   {31'h0, done}, 32'd0);
    chk("rst_result", {16'h0, result}, 32'h0);
    chk("rst_flags",  {28'h0, flag_dz, flag_nv, flag_of, flag_uf}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #2;

    // Normal path
    run(16'h3C00, 16'h3C00, 16'h3C00, 4'b0000, 14);
    run(16'h4200, 16'h4000, 16'h3E00, 4'b0000, 14);
    run(16'h3C00, 16'h4200, 16'h3555, 4'b0000, 14);
    run(16'hC400, 16'h4000, 16'hC000, 4'b0000, 14);
    run(16'h7BFF, 16'h1400, 16'h7C00, 4'b0010, 14);
    run(16'h0400, 16'h7BFF, 16'h0000, 4'b0001, 14);
    // Special path
    run(16'h4000, 16'h0000, 16'h7C00, 4'b1000, 1);
    run(16'h0000, 16'h0000, 16'h7E00, 4'b0100, 1);
    run(16'h7C01, 16'h3C00, 16'h7E00, 4'b0100, 1);
    run(16'h8000, 16'h3C00, 16'h8000, 4'b0000, 1);
    run(16'h0001, 16'h3C00, 16'h0000, 4'b0000, 1);
    run(16'h7C00, 16'h7C00, 16'h7E00, 4'b0100, 1);
    run(16'h7C00, 16'h0000, 16'h7C00, 4'b0000, 1);
    run(16'h3C00, 16'h7C00, 16'h0000, 4'b0000, 1);
    run(16'hC000, 16'h0000, 16'hFC00, 4'b1000, 1);

    // start during busy is ignored, operand changes have no effect
    issue(16'h4200, 16'h4000, 16'h3E00, 4'b0000, 14);
    repeat (4) begin @(posedge clk); #2; end
    op1 = 16'h3C00; op2 = 16'h4200; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    wait_done();
    // start in the done cycle is accepted
    issue(16'h3C00, 16'h4200, 16'h3555, 4'b0000, 14);
    wait_done();
    @(posedge clk); #2;
    chk("queue_drained", sb.size(), 32'd0);

    // asynchronous reset mid-operation
    issue(16'h4200, 16'h4000, 16'h3E00, 4'b0000, 14);
    repeat (6) begin @(posedge clk); #2; end
    rst = 1'b1;
    #1;
    chk("abort_busy",   {31'h0, busy}, 32'd0);
    chk("abort_done",   {31'h0, done}, 32'd0);
    chk("abort_result", {16'h0, result}, 32'h0);
    sb.delete();
    @(posedge clk); #2;
    rst = 1'b0;
    repeat (20) begin @(posedge clk); #2; end
    chk("abort_no_done", {31'h0, done}, 32'd0);
    run(16'h4200, 16'h4000, 16'h3E00, 4'b0000, 14);
    chk("final_drained", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
